// File: rtl/spi_xip_pkg.sv
// spi_xip_pkg: shared definitions for the SPI flash execute-in-place sequencer.
// Holds the sequencer state encoding, the SPI master register offsets, the
// CTRL register bit positions, the flash READ opcode and a byte-swap helper.
package spi_xip_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PASS,
        ST_ERR,
        ST_W_DIV,
        ST_W_SS,
        ST_W_TX1,
        ST_W_TX0,
        ST_W_GO,
        ST_POLL,
        ST_R_RX,
        ST_W_DESEL,
        ST_DONE
    } xip_state_t;

    // SPI master register offsets (low five address bits).
    localparam logic [4:0] OFF_RX0     = 5'h00;
    localparam logic [4:0] OFF_TX0     = 5'h00;
    localparam logic [4:0] OFF_TX1     = 5'h04;
    localparam logic [4:0] OFF_CTRL    = 5'h10;
    localparam logic [4:0] OFF_DIVIDER = 5'h14;
    localparam logic [4:0] OFF_SS      = 5'h18;

    // CTRL register fields.
    localparam int         CTRL_GO_BSY      = 8;
    localparam int         CTRL_TX_NEG      = 10;
    localparam logic [6:0] CTRL_CHAR_LEN_64 = 7'd64;

    // GO + TX_NEG + 64-bit frame: 8-bit opcode, 24-bit address, 32 data bits.
    localparam logic [31:0] CTRL_XIP_GO = (32'd1 << CTRL_GO_BSY)
                                        | (32'd1 << CTRL_TX_NEG)
                                        | 32'(CTRL_CHAR_LEN_64);

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_xip_apb_master_port.sv
// apb_master_port: runs one APB transfer (setup cycle, then access cycle held
// until pready) for as long as req_i is held high.
// Request side : req_i, addr_i, write_i, wdata_i, strb_i, prot_i
// Result side  : done_o (one cycle, the cycle pready is seen), rdata_o, err_o
// APB master   : paddr_o, psel_o, penable_o, pprot_o, pwrite_o, pwdata_o,
//                pstrb_o / pready_i, prdata_i, pslverr_i
// Debug        : access_o shows the setup/access phase register.
// Handshake: the requester holds req_i and the request fields stable until
// done_o; dropping req_i returns the port to setup phase with no bus activity.
// When req_i is low every APB output is 0.
module apb_master_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  strb_i,
    input  logic [2:0]  prot_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        access_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic [2:0]  pprot_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    logic access_q, access_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            access_q <= 1'b0;
        end else begin
            access_q <= access_d;
        end
    end

    always_comb begin
        access_d  = 1'b0;
        done_o    = 1'b0;
        rdata_o   = '0;
        err_o     = 1'b0;
        paddr_o   = '0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        pprot_o   = '0;
        pwrite_o  = 1'b0;
        pwdata_o  = '0;
        pstrb_o   = '0;
        if (req_i) begin
            psel_o   = 1'b1;
            paddr_o  = addr_i;
            pprot_o  = prot_i;
            pwrite_o = write_i;
            pwdata_o = wdata_i;
            pstrb_o  = strb_i;
            if (!access_q) begin
                access_d = 1'b1;
            end else begin
                penable_o = 1'b1;
                access_d  = 1'b1;
                if (pready_i) begin
                    done_o   = 1'b1;
                    rdata_o  = prdata_i;
                    err_o    = pslverr_i;
                    access_d = 1'b0;
                end
            end
        end
    end

    assign access_o = access_q;

endmodule

// File: rtl/spi_flash_xip.sv
// spi_flash_xip: execute-in-place sequencer between the CPU APB bus and the
// SPI master register file. Reads inside [flash_addr_start, flash_addr_end]
// run a fixed SPI register program (divider, select, TX words, GO, busy poll,
// RX read, deselect) and return the flash word; writes inside the window get
// an error response; everything else passes straight through to the SPI
// registers.
// Parameters : flash_addr_start, flash_addr_end, spi_div, flash_ss
// Ports      : clock, reset (sync, active high)
//              in_*  APB slave from the CPU
//              out_* APB master to the SPI register file
//              dbg_state_o current sequencer state
// Build macro: SPI_XIP_BSWAP_EN byte-swaps the returned flash word (little-
//              endian view of the byte stream); undefined returns raw RX0.
// Handshake: a request is accepted on in_psel && !in_penable in IDLE and no
// other request is taken until in_pready has been given for it; in_pready is
// only raised while the CPU holds in_penable.
module spi_flash_xip
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] flash_addr_start = 32'h3000_0000,
    parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
    parameter logic [15:0] spi_div          = 16'h0001,
    parameter logic [7:0]  flash_ss         = 8'h01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    output xip_state_t  dbg_state_o
);

    xip_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [2:0]  prot_q, prot_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        m_req, m_write, m_done, m_err, m_access;
    logic [31:0] m_addr, m_wdata, m_rdata, rx_word;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    logic        in_win, in_prog;
    xip_state_t  prog_next;

    assign in_win = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);

`ifdef SPI_XIP_BSWAP_EN
    assign rx_word = bswap32(m_rdata);
`else
    assign rx_word = m_rdata;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        prot_d     = prot_q;
        data_d     = data_q;
        err_d      = err_q;
        m_req      = 1'b0;
        m_addr     = {addr_q[31:5], OFF_RX0};
        m_write    = 1'b0;
        m_wdata    = '0;
        m_strb     = '0;
        m_prot     = '0;
        in_pready  = 1'b0;
        in_prdata  = '0;
        in_pslverr = 1'b0;
        in_prog    = 1'b0;
        prog_next  = ST_W_DESEL;

        case (state_q)
            ST_IDLE: begin
                if (in_psel && !in_penable) begin
                    addr_d  = in_paddr;
                    write_d = in_pwrite;
                    wdata_d = in_pwdata;
                    strb_d  = in_pstrb;
                    prot_d  = in_pprot;
                    data_d  = '0;
                    err_d   = 1'b0;
                    if (!in_win)        state_d = ST_PASS;
                    else if (in_pwrite) state_d = ST_ERR;
                    else                state_d = ST_W_DIV;
                end
            end
            ST_PASS: begin
                m_req   = 1'b1;
                m_addr  = addr_q;
                m_write = write_q;
                m_wdata = wdata_q;
                m_strb  = strb_q;
                m_prot  = prot_q;
                if (m_done) begin
                    in_pready  = 1'b1;
                    in_prdata  = m_rdata;
                    in_pslverr = m_err;
                    state_d    = ST_IDLE;
                end
            end
            ST_ERR: begin
                in_pready  = 1'b1;
                in_pslverr = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_W_DIV: begin
                m_req = 1'b1; in_prog = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr    = {addr_q[31:5], OFF_DIVIDER};
                m_wdata   = {16'h0, spi_div};
                prog_next = ST_W_SS;
            end
            ST_W_SS: begin
                m_req = 1'b1; in_prog = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr    = {addr_q[31:5], OFF_SS};
                m_wdata   = {24'h0, flash_ss};
                prog_next = ST_W_TX1;
            end
            ST_W_TX1: begin
                // Opcode and word-aligned 24-bit flash address go out first.
                m_req = 1'b1; in_prog = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr    = {addr_q[31:5], OFF_TX1};
                m_wdata   = {FLASH_CMD_READ, addr_q[23:2], 2'b00};
                prog_next = ST_W_TX0;
            end
            ST_W_TX0: begin
                m_req = 1'b1; in_prog = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr    = {addr_q[31:5], OFF_TX0};
                prog_next = ST_W_GO;
            end
            ST_W_GO: begin
                m_req = 1'b1; in_prog = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr    = {addr_q[31:5], OFF_CTRL};
                m_wdata   = CTRL_XIP_GO;
                prog_next = ST_POLL;
            end
            ST_POLL: begin
                m_req = 1'b1; in_prog = 1'b1;
                m_addr    = {addr_q[31:5], OFF_CTRL};
                prog_next = m_rdata[CTRL_GO_BSY] ? ST_POLL : ST_R_RX;
            end
            ST_R_RX: begin
                m_req = 1'b1; in_prog = 1'b1;
                m_addr    = {addr_q[31:5], OFF_RX0};
                prog_next = ST_W_DESEL;
                if (m_done && !m_err) data_d = rx_word;
            end
            ST_W_DESEL: begin
                // Always reached, also after an abort, so the flash is released.
                m_req = 1'b1; m_write = 1'b1; m_strb = 4'hf;
                m_addr = {addr_q[31:5], OFF_SS};
                if (m_done) begin
                    if (m_err) err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                in_pready  = 1'b1;
                in_pslverr = err_q;
                in_prdata  = err_q ? 32'h0 : data_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any slave error inside the program skips straight to deselect.
        if (in_prog && m_done) begin
            if (m_err) begin
                err_d   = 1'b1;
                state_d = ST_W_DESEL;
            end else begin
                state_d = prog_next;
            end
        end
    end

    apb_master_port u_port (
        .clock     (clock),
        .reset     (reset),
        .req_i     (m_req),
        .addr_i    (m_addr),
        .write_i   (m_write),
        .wdata_i   (m_wdata),
        .strb_i    (m_strb),
        .prot_i    (m_prot),
        .done_o    (m_done),
        .rdata_o   (m_rdata),
        .err_o     (m_err),
        .access_o  (m_access),
        .paddr_o   (out_paddr),
        .psel_o    (out_psel),
        .penable_o (out_penable),
        .pprot_o   (out_pprot),
        .pwrite_o  (out_pwrite),
        .pwdata_o  (out_pwdata),
        .pstrb_o   (out_pstrb),
        .pready_i  (out_pready),
        .prdata_i  (out_prdata),
        .pslverr_i (out_pslverr)
    );

    // The port's phase bit is fully implied by out_penable; kept for probing.
    logic unused_access;
    assign unused_access = m_access;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_xip.sv
// Bench for spi_flash_xip: CPU-side APB driver, an SPI register-file responder
// that logs every completed out transaction, and a reference model that lists
// the expected out transactions and CPU response for each request.
module tb_spi_flash_xip;
    import spi_xip_pkg::*;

    localparam logic [31:0] WIN_LO = 32'h3000_0000;
    localparam logic [31:0] WIN_HI = 32'h3fff_ffff;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel, in_penable, in_pwrite;
    logic [2:0]  in_pprot;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    xip_state_t  dbg_state;

    always #5 clock = ~clock;

    spi_flash_xip dut (
        .clock       (clock),
        .reset       (reset),
        .in_paddr    (in_paddr),
        .in_psel     (in_psel),
        .in_penable  (in_penable),
        .in_pprot    (in_pprot),
        .in_pwrite   (in_pwrite),
        .in_pwdata   (in_pwdata),
        .in_pstrb    (in_pstrb),
        .in_pready   (in_pready),
        .in_prdata   (in_prdata),
        .in_pslverr  (in_pslverr),
        .out_paddr   (out_paddr),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pprot   (out_pprot),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_pready  (out_pready),
        .out_prdata  (out_prdata),
        .out_pslverr (out_pslverr),
        .dbg_state_o (dbg_state)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // {write, paddr, wdata (0 for reads)}
    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];

    // SPI register-file responder settings
    int          slv_wait  = 0;
    int          busy_left = 0;
    int          err_idx   = -1;
    int          tidx      = 0;
    int          wcnt      = 0;
    logic        pass_mode = 1'b0;
    logic [31:0] rx_word   = '0;
    logic [31:0] pass_word = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responder: reacts just after each rising edge to the access phase.
    always @(posedge clock) begin
        #1;
        if (reset || !(out_psel && out_penable)) begin
            out_pready  = 1'b0;
            out_prdata  = '0;
            out_pslverr = 1'b0;
            wcnt        = 0;
        end else if (wcnt < slv_wait) begin
            wcnt++;
            out_pready = 1'b0;
        end else begin
            wcnt        = 0;
            out_pready  = 1'b1;
            out_pslverr = (tidx == err_idx);
            out_prdata  = '0;
            if (!out_pwrite) begin
                if (pass_mode) out_prdata = pass_word;
                else if (out_paddr[4:0] == 5'h10) begin
                    out_prdata = (busy_left > 0) ? 32'h0000_0540 : 32'h0000_0440;
                    if (busy_left > 0) busy_left--;
                end else if (out_paddr[4:0] == 5'h00) out_prdata = rx_word;
                else out_prdata = 32'hbad0_bad0;
            end
            obs_q.push_back({out_pwrite, out_paddr, out_pwrite ? out_pwdata : 32'h0});
            tidx++;
        end
    end

    // in_pready must only appear while the CPU holds penable.
    always @(negedge clock) begin
        if (in_pready) begin
            n_vec++;
            if (!in_penable) begin
                n_fail++;
                $display("FAIL pready_without_penable: penable %0b, required 1", in_penable);
            end
        end
    end

    function automatic logic [31:0] cpu_view(input logic [31:0] rx);
`ifdef SPI_XIP_BSWAP_EN
        return ((rx & 32'h0000_00ff) << 24) | ((rx & 32'h0000_ff00) << 8)
             | ((rx >> 8) & 32'h0000_ff00) | (rx >> 24);
`else
        return rx;
`endif
    endfunction

    // Reference model: expected out transactions (into exp_q) and response.
    task automatic model(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input int polls, input int eidx, input logic [31:0] rx,
                         input logic [31:0] pw, input int w,
                         output logic [31:0] e_rdata, output logic e_err, output int e_lat);
        logic [64:0] prog[$];
        logic [64:0] desel;
        logic [31:0] base;
        int np;
        exp_q.delete();
        if (!(a >= WIN_LO && a <= WIN_HI)) begin
            exp_q.push_back({wr, a, wr ? wd : 32'h0});
            e_err   = (eidx == 0);
            e_rdata = wr ? 32'h0 : pw;
            e_lat   = 3 + w;
        end else if (wr) begin
            e_err = 1'b1; e_rdata = '0; e_lat = 2;
        end else begin
            base = a & 32'hffff_ffe0;
            prog.push_back({1'b1, base | 32'h14, 32'h0000_0001});
            prog.push_back({1'b1, base | 32'h18, 32'h0000_0001});
            prog.push_back({1'b1, base | 32'h04, 32'h0300_0000 | (a & 32'h00ff_fffc)});
            prog.push_back({1'b1, base, 32'h0});
            prog.push_back({1'b1, base | 32'h10, 32'h0000_0540});
            for (int i = 0; i < polls; i++) prog.push_back({1'b0, base | 32'h10, 32'h0});
            prog.push_back({1'b0, base, 32'h0});
            desel = {1'b1, base | 32'h18, 32'h0};
            np = prog.size();
            if (eidx >= 0 && eidx < np) begin
                for (int i = 0; i <= eidx; i++) exp_q.push_back(prog[i]);
                e_err = 1'b1;
            end else begin
                for (int i = 0; i < np; i++) exp_q.push_back(prog[i]);
                e_err = (eidx == np);
            end
            exp_q.push_back(desel);
            e_rdata = e_err ? 32'h0 : cpu_view(rx);
            e_lat   = 2 + exp_q.size() * (2 + w);
        end
    endtask

    // One CPU APB access; lat counts cycles from setup to in_pready inclusive.
    task automatic cpu_access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
        int k;
        bit got;
        @(posedge clock); #1;
        in_paddr = a; in_pwrite = wr; in_pwdata = wd; in_pstrb = wr ? 4'hf : 4'h0;
        in_pprot = 3'b000; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        k = 1; got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        while (!got && k < 400) begin
            @(negedge clock);
            if (in_pready) begin
                got = 1'b1; rd = in_prdata; er = in_pslverr; lat = k + 1;
            end
            @(posedge clock); #1;
            if (!got) k++;
        end
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic wr,
                           input logic [31:0] wd, input int polls, input int eidx,
                           input logic [31:0] rx, input logic [31:0] pw, input int w,
                           input logic [31:0] e_rdata, input logic e_err, input int e_lat);
        logic [31:0] rd, m_rd;
        logic er, m_er;
        int lat, m_lat, n;
        obs_q.delete();
        busy_left = polls - 1; rx_word = rx; pass_word = pw; slv_wait = w;
        err_idx = eidx; tidx = 0; pass_mode = !(a >= WIN_LO && a <= WIN_HI);
        model(a, wr, wd, polls, eidx, rx, pw, w, m_rd, m_er, m_lat);
        cpu_access(a, wr, wd, rd, er, lat);
        chk($sformatf("%s latency", tag), lat, e_lat);
        chk($sformatf("%s prdata", tag), rd, e_rdata);
        chk($sformatf("%s pslverr", tag), er, e_err);
        @(negedge clock);
        chk($sformatf("%s single_pready", tag), in_pready, 1'b0);
        chk($sformatf("%s n_out", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s out[%0d]", tag, i), obs_q[i], exp_q[i]);
        if (lat < 0) begin
            @(posedge clock); #1; reset = 1'b1;
            @(posedge clock); #1; reset = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        int          polls;
        int          eidx;
        logic [31:0] rx;
        logic [31:0] pw;
        int          w;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd, rx, pw, e_rd;
        logic wr, e_er;
        int polls, eidx, w, e_lat, kind, k;

        tbl[0]  = '{32'h3000_0104, 1'b0, 32'h0, 1, -1, 32'h1122_3344, 32'h0, 0, cpu_view(32'h1122_3344), 1'b0, 18};
        tbl[1]  = '{32'h3000_abc8, 1'b0, 32'h0, 5, -1, 32'hdead_beef, 32'h0, 0, cpu_view(32'hdead_beef), 1'b0, 26};
        tbl[2]  = '{32'h3000_0000, 1'b1, 32'h1234_5678, 1, -1, 32'h0, 32'h0, 0, 32'h0, 1'b1, 2};
        tbl[3]  = '{32'h1000_1014, 1'b0, 32'h0, 1, -1, 32'h0, 32'hcafe_f00d, 0, 32'hcafe_f00d, 1'b0, 3};
        tbl[4]  = '{32'h3000_0010, 1'b0, 32'h0, 1, 2, 32'h55aa_55aa, 32'h0, 0, 32'h0, 1'b1, 10};
        tbl[5]  = '{32'h3fff_fffc, 1'b0, 32'h0, 2, -1, 32'h0bad_f00d, 32'h0, 0, cpu_view(32'h0bad_f00d), 1'b0, 20};
        tbl[6]  = '{32'h2fff_fffc, 1'b0, 32'h0, 1, -1, 32'h0, 32'h1357_9bdf, 0, 32'h1357_9bdf, 1'b0, 3};
        tbl[7]  = '{32'h4000_0000, 1'b1, 32'ha5a5_a5a5, 1, -1, 32'h0, 32'h0, 1, 32'h0, 1'b0, 4};
        tbl[8]  = '{32'h30f0_0004, 1'b0, 32'h0, 1, -1, 32'h89ab_cdef, 32'h0, 2, cpu_view(32'h89ab_cdef), 1'b0, 34};
        tbl[9]  = '{32'h3000_0020, 1'b0, 32'h0, 3, 9, 32'h7777_1111, 32'h0, 0, 32'h0, 1'b1, 22};
        tbl[10] = '{32'h0000_0008, 1'b0, 32'h0, 1, 0, 32'h0, 32'h0f0f_0f0f, 0, 32'h0f0f_0f0f, 1'b1, 3};
        tbl[11] = '{32'h3000_0040, 1'b0, 32'h0, 3, 6, 32'h2468_ace0, 32'h0, 0, 32'h0, 1'b1, 18};

        // Clock/reset
        reset = 1'b1; in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = '0;
        in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset outputs", {out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata,
                              out_pstrb, in_pready, in_prdata, in_pslverr}, '0);
        chk("reset state", dbg_state, ST_IDLE);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].polls,
                    tbl[i].eidx, tbl[i].rx, tbl[i].pw, tbl[i].w,
                    tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_lat);

        // Reset while the sequencer is busy-polling.
        obs_q.delete();
        busy_left = 100; pass_mode = 1'b0; err_idx = -1; tidx = 0; slv_wait = 0;
        @(posedge clock); #1;
        in_paddr = 32'h3000_0200; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        k = 0;
        while (tidx < 7 && k < 200) begin
            @(posedge clock); #2;
            k++;
        end
        chk("reach poll", tidx >= 7, 1'b1);
        reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mid-poll reset outputs", {out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
                                       out_pwdata, out_pstrb, in_pready, in_prdata, in_pslverr}, '0);
        chk("mid-poll reset state", dbg_state, ST_IDLE);
        @(posedge clock); #1;
        reset = 1'b0;
        run_vec("after_reset", 32'h3000_0300, 1'b0, 32'h0, 1, -1, 32'h7654_3210, 32'h0, 0,
                cpu_view(32'h7654_3210), 1'b0, 18);

        // Randomised requests against the model.
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 9);
            polls = $urandom_range(1, 4);
            w     = $urandom_range(0, 2);
            rx    = $urandom;
            pw    = $urandom;
            wd    = $urandom;
            eidx  = -1;
            if (kind <= 5) begin
                a = WIN_LO | ($urandom & 32'h0fff_ffff); wr = 1'b0;
                if ($urandom_range(0, 3) == 0) eidx = $urandom_range(0, 6 + polls);
            end else if (kind == 6) begin
                a = WIN_LO | ($urandom & 32'h0fff_ffff); wr = 1'b1;
            end else begin
                a = $urandom;
                if (a >= WIN_LO && a <= WIN_HI) a = a ^ 32'h8000_0000;
                wr = $urandom_range(0, 1);
                if ($urandom_range(0, 3) == 0) eidx = 0;
            end
            model(a, wr, wd, polls, eidx, rx, pw, w, e_rd, e_er, e_lat);
            run_vec($sformatf("rnd%0d", n), a, wr, wd, polls, eidx, rx, pw, w, e_rd, e_er, e_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
